// File: rtl/tx_ipv4.sv
// tx_ipv4: IPv4 transmit framer; builds a 20-byte header with checksum, then streams the payload
module tx_ipv4 #(
  parameter int          OCT       = 8,
  parameter logic [7:0]  PROTOCOL  = 8'h11,
  parameter logic [7:0]  TTL       = 8'd64,
  parameter logic [15:0] FLAG_FRAG = 16'h4000
) (
  input  logic           TX_CLK,
  input  logic           rst,
  input  logic           func_en,
  input  logic [31:0]    ip_addr,
  input  logic [31:0]    tx_dst_ip,
  input  logic [15:0]    tx_payload_len,
  input  logic           tx_start,
  output logic           tx_busy,
  output logic           tx_ipv4_irq,
  input  logic           tx_payload_v,
  input  logic [OCT-1:0] tx_payload_data,
  output logic           tx_payload_rdy,
  output logic           tx_ipv4_data_v,
  output logic [OCT-1:0] tx_ipv4_data,
  input  logic           tx_ethernet_rdy
);
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAY, DRAIN} state_t;
  state_t         state_q, state_d;
  logic [31:0]    dst_q, dst_d, src_q, src_d;
  logic [15:0]    len_q, len_d, tot_q, tot_d, id_q, id_d, idcnt_q, idcnt_d;
  logic [15:0]    csum_q, csum_d, rem_q, rem_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [OCT-1:0] data_q, data_d, hdr_byte;
  logic           valid_q, valid_d, busy_q, busy_d, irq_q, irq_d, load;
  logic [19:0]    s0, s1;
  logic [15:0]    s2;
  logic [159:0]   hdr;
  assign load = !valid_q || tx_ethernet_rdy;
  assign s0 = {4'h0, 16'h4500} + {4'h0, tot_q} + {4'h0, id_q} + {4'h0, FLAG_FRAG} + {4'h0, TTL, PROTOCOL}
            + {4'h0, src_q[31:16]} + {4'h0, src_q[15:0]} + {4'h0, dst_q[31:16]} + {4'h0, dst_q[15:0]};
  assign s1 = {4'h0, s0[15:0]} + {16'h0, s0[19:16]};
  assign s2 = s1[15:0] + {12'h0, s1[19:16]};
  assign hdr = {16'h4500, tot_q, id_q, FLAG_FRAG, TTL, PROTOCOL, csum_q, src_q, dst_q};
  assign hdr_byte = OCT'(hdr >> (8'd152 - {cnt_q, 3'b000}));
  assign tx_payload_rdy = (state_q == PAY) && load;
  assign tx_ipv4_data_v = valid_q;
  assign tx_ipv4_data = data_q;
  assign tx_busy = busy_q;
  assign tx_ipv4_irq = irq_q;
  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state_q <= IDLE;
      dst_q <= '0;
      src_q <= '0;
      len_q <= '0;
      tot_q <= '0;
      id_q <= '0;
      idcnt_q <= '0;
      csum_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q <= dst_d;
      src_q <= src_d;
      len_q <= len_d;
      tot_q <= tot_d;
      id_q <= id_d;
      idcnt_q <= idcnt_d;
      csum_q <= csum_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      irq_q <= irq_d;
    end
  end
  // Next-state logic: latch on start, checksum, header bytes, payload pass-through, drain last byte
  always_comb begin
    state_d = state_q;
    dst_d = dst_q;
    src_d = src_q;
    len_d = len_q;
    tot_d = tot_q;
    id_d = id_q;
    idcnt_d = idcnt_q;
    csum_d = csum_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    data_d = data_q;
    valid_d = valid_q;
    busy_d = busy_q;
    irq_d = 1'b0;
    case (state_q)
      IDLE: if (tx_start && func_en && !irq_q) begin
        dst_d = tx_dst_ip;
        src_d = ip_addr;
        len_d = tx_payload_len;
        tot_d = tx_payload_len + 16'd20;
        id_d = idcnt_q;
        busy_d = 1'b1;
        state_d = CSUM;
      end
      CSUM: begin
        csum_d = ~s2;
        cnt_d = '0;
        rem_d = len_q;
        state_d = HDR;
      end
      HDR: if (load) begin
        data_d = hdr_byte;
        valid_d = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = (len_q == 16'd0) ? DRAIN : PAY;
      end
      PAY: if (load) begin
        valid_d = tx_payload_v;
        if (tx_payload_v) begin
          data_d = tx_payload_data;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = DRAIN;
        end
      end
      DRAIN: if (valid_q && tx_ethernet_rdy) begin
        valid_d = 1'b0;
        irq_d = 1'b1;
        busy_d = 1'b0;
        idcnt_d = idcnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tx_ipv4.sv
// tb_tx_ipv4: randomized scoreboard bench for the IPv4 transmit framer
module tb_tx_ipv4;
  logic TX_CLK = 0, rst = 1, func_en = 0, tx_start = 0, tx_payload_v = 0, tx_ethernet_rdy = 1;
  logic [31:0] ip_addr = 0, tx_dst_ip = 0;
  logic [15:0] tx_payload_len = 0;
  logic [7:0] tx_payload_data = 0;
  logic tx_busy, tx_ipv4_irq, tx_payload_rdy, tx_ipv4_data_v;
  logic [7:0] tx_ipv4_data;
  int checks = 0, errors = 0;
  byte unsigned expq[$], payq[$], got[$];
  int irq_cnt = 0, nacc = 0, idle_busy = 0;
  logic [15:0] model_id = 0;
  bit bp = 0;
  int gap_at = -1, gap_left = 0, npay = 0;
  logic hold_v = 0;
  logic [7:0] hold_d = 0;

  always #5 TX_CLK = ~TX_CLK;

  tx_ipv4 dut (
    .TX_CLK(TX_CLK), .rst(rst), .func_en(func_en), .ip_addr(ip_addr), .tx_dst_ip(tx_dst_ip),
    .tx_payload_len(tx_payload_len), .tx_start(tx_start), .tx_busy(tx_busy), .tx_ipv4_irq(tx_ipv4_irq),
    .tx_payload_v(tx_payload_v), .tx_payload_data(tx_payload_data), .tx_payload_rdy(tx_payload_rdy),
    .tx_ipv4_data_v(tx_ipv4_data_v), .tx_ipv4_data(tx_ipv4_data), .tx_ethernet_rdy(tx_ethernet_rdy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference header: ten big-endian words, end-around-carry sum, one's complement
  function automatic void model_frame(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len, input logic [15:0] id);
    logic [15:0] w[10];
    int unsigned sum;
    w = '{16'h4500, len + 16'd20, id, 16'h4000, 16'h4011, 16'h0000, src[31:16], src[15:0], dst[31:16], dst[15:0]};
    sum = 0;
    foreach (w[i]) sum += w[i];
    while (sum > 32'hffff) sum = (sum & 32'hffff) + (sum >> 16);
    w[5] = ~sum[15:0];
    foreach (w[i]) begin
      expq.push_back(w[i][15:8]);
      expq.push_back(w[i][7:0]);
    end
  endfunction

  // Monitor: compares each byte accepted downstream against the scoreboard queue
  always @(negedge TX_CLK) begin
    if (rst) hold_v <= 1'b0;
    else begin
      if (hold_v) begin
        check("hold_valid", tx_ipv4_data_v, 1);
        check("hold_data", tx_ipv4_data, hold_d);
      end
      hold_v <= tx_ipv4_data_v && !tx_ethernet_rdy;
      hold_d <= tx_ipv4_data;
      if (tx_busy && !tx_ipv4_data_v) idle_busy <= idle_busy + 1;
      if (tx_ipv4_data_v && tx_ethernet_rdy) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h with no byte expected", tx_ipv4_data);
        end else check("byte", tx_ipv4_data, expq.pop_front());
        got.push_back(tx_ipv4_data);
        nacc <= nacc + 1;
      end
      if (tx_ipv4_irq) begin
        check("irq_after_last_byte", expq.size(), 0);
        irq_cnt <= irq_cnt + 1;
      end
    end
  end

  // One clock of upstream/downstream driving; inputs change 1 time unit after the edge
  task automatic cycle();
    bit acc;
    @(negedge TX_CLK);
    acc = tx_payload_v && tx_payload_rdy;
    @(posedge TX_CLK);
    #1;
    tx_start = 0;
    if (acc) begin
      void'(payq.pop_front());
      npay++;
    end
    tx_ethernet_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    if (gap_at >= 0 && npay >= gap_at && gap_left > 0) begin
      tx_payload_v = 0;
      gap_left--;
    end else tx_payload_v = payq.size() > 0;
    tx_payload_data = payq.size() > 0 ? payq[0] : 8'h00;
  endtask

  task automatic run_frame(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                           input bit bpi, input int gapi, input int rst_at, input bit seq, input int exp_cs);
    int base_acc, base_irq, base_idle, gbase, n;
    bit done;
    byte unsigned b;
    bp = bpi;
    gap_at = gapi;
    gap_left = 3;
    npay = 0;
    model_frame(src, dst, len, model_id);
    for (int i = 0; i < int'(len); i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom);
      payq.push_back(b);
      expq.push_back(b);
    end
    base_acc = nacc;
    base_irq = irq_cnt;
    base_idle = idle_busy;
    gbase = got.size();
    ip_addr = src;
    tx_dst_ip = dst;
    tx_payload_len = len;
    func_en = 1;
    tx_start = 1;
    tx_payload_v = payq.size() > 0;
    tx_payload_data = payq.size() > 0 ? payq[0] : 8'h00;
    cycle();
    ip_addr = $urandom;
    tx_dst_ip = $urandom;
    tx_payload_len = 16'($urandom);
    check("busy_after_start", tx_busy, 1);
    check("latency_csum_valid", tx_ipv4_data_v, 0);
    cycle();
    check("latency_edge1_valid", tx_ipv4_data_v, 0);
    cycle();
    check("latency_edge2_valid", tx_ipv4_data_v, 1);
    n = 0;
    done = 0;
    while (!done && n < 2000) begin
      if (n == 3) tx_start = 1;
      if (n == 5) func_en = 0;
      if (rst_at > 0 && nacc - base_acc == rst_at) begin
        rst = 1;
        cycle();
        rst = 0;
        check("rst_valid", tx_ipv4_data_v, 0);
        check("rst_data", tx_ipv4_data, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_irq", tx_ipv4_irq, 0);
        check("rst_payload_rdy", tx_payload_rdy, 0);
        expq.delete();
        payq.delete();
        model_id = 0;
        for (int i = 0; i < 10; i++) cycle();
        check("no_irq_after_reset", irq_cnt - base_irq, 0);
        done = 1;
      end else begin
        cycle();
        n++;
        if (tx_ipv4_irq) begin
          func_en = 1;
          tx_start = 1;
        end
        if (irq_cnt != base_irq) done = 1;
      end
    end
    check("frame_done", done, 1);
    if (rst_at <= 0) begin
      for (int i = 0; i < 4; i++) cycle();
      check("irq_count", irq_cnt - base_irq, 1);
      check("busy_cleared", tx_busy, 0);
      check("frame_bytes", nacc - base_acc, 20 + int'(len));
      check("total_len", {got[gbase + 2], got[gbase + 3]}, len + 16'd20);
      check("ip_id", {got[gbase + 4], got[gbase + 5]}, model_id);
      if (!bpi) check("busy_idle_cycles", idle_busy - base_idle, gapi >= 0 ? 5 : 2);
      if (exp_cs >= 0) check("checksum", {got[gbase + 10], got[gbase + 11]}, exp_cs);
      model_id++;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cycle();
    check("reset_valid", tx_ipv4_data_v, 0);
    check("reset_data", tx_ipv4_data, 0);
    check("reset_busy", tx_busy, 0);
    check("reset_irq", tx_ipv4_irq, 0);
    check("reset_payload_rdy", tx_payload_rdy, 0);
    rst = 0;
    cycle();
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd8, 0, -1, 0, 1, 'hB775);
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd8, 0, -1, 0, 1, 'hB774);
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd8, 1, -1, 0, 1, -1);
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd8, 0, 3, 0, 1, -1);
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd0, 0, -1, 0, 0, -1);
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd0, 1, -1, 0, 0, -1);
    func_en = 0;
    tx_start = 1;
    cycle();
    check("start_disabled_busy", tx_busy, 0);
    for (int i = 0; i < 5; i++) cycle();
    check("start_disabled_valid", tx_ipv4_data_v, 0);
    for (int k = 0; k < 8; k++)
      run_frame($urandom, $urandom, 16'($urandom_range(1, 40)), k[0], k == 3 ? 5 : -1, 0, 0, -1);
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd8, 0, -1, 24, 1, -1);
    run_frame(32'hC0A8010A, 32'hC0A80101, 16'd8, 0, -1, 0, 1, 'hB775);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_ipv4.md
Name: tx_ipv4

Overview:
IPv4 transmit framer. On a start pulse it builds a 20-byte IPv4 header with no options, computing the header checksum internally. It streams the header and then the upstream payload bytes, one byte per accepted transfer, to the Ethernet MAC transmit layer. It sits between the UDP transmit block (payload source) and the Ethernet framer (byte sink) in the TX_CLK domain.

Parameters:
OCT, 8, byte width.
PROTOCOL, 8'h11, value of the IPv4 protocol field (UDP).
TTL, 8'd64, value of the IPv4 TTL field.
FLAG_FRAG, 16'h4000, flags/fragment-offset field (DF set, offset 0).

Ports:
TX_CLK  in  1  clock; the only clock.
rst  in  1  synchronous, active-high reset.
func_en  in  1  block enable; tx_start is accepted only while high.
ip_addr  in  32  local IP address, used as the source IP.
tx_dst_ip  in  32  destination IP; sampled on start.
tx_payload_len  in  16  payload byte count; sampled on start.
tx_start  in  1  one-cycle start request.
tx_busy  out  1  high from start acceptance until the frame is done.
tx_ipv4_irq  out  1  one-cycle pulse when the last byte is accepted downstream.
tx_payload_v  in  1  upstream payload byte valid.
tx_payload_data  in  8  upstream payload byte.
tx_payload_rdy  out  1  payload byte accepted when tx_payload_v and tx_payload_rdy are both high (combinational).
tx_ipv4_data_v  out  1  output byte valid (registered).
tx_ipv4_data  out  8  output byte (registered).
tx_ethernet_rdy  in  1  downstream accepts the byte when tx_ipv4_data_v and tx_ethernet_rdy are both high.

Behaviour:
- Reset values: all outputs are 0, the state is IDLE, and the ID counter is 16'h0000. Reset in mid-frame aborts the frame immediately with no irq.
- Output register loads a new byte only when load = !tx_ipv4_data_v || tx_ethernet_rdy. Otherwise it holds both data and valid.
- IDLE: if tx_start && func_en, latch dst_ip, src_ip (= ip_addr), payload_len, total_len = (payload_len + 20) mod 2^16, and id = ID counter. Then go to CSUM and set tx_busy. tx_start at any other time is ignored.
- CSUM (1 cycle): sum the ten 16-bit header words as a 20-bit sum, with the checksum word taken as 0. The words are 16'h4500, total_len, id, FLAG_FRAG, {TTL, PROTOCOL}, src[31:16], src[15:0], dst[31:16], dst[15:0]. Fold the carries twice (s = s[15:0] + s[19:16], repeated), then invert to form the checksum. Go to HDR with hdr_cnt = 0.
- HDR: on each load, output header byte hdr_cnt with valid = 1. The byte order is big-endian: 45, 00, total_len[15:8], total_len[7:0], id hi, id lo, flag hi, flag lo, TTL, PROTOCOL, csum hi, csum lo, src[31:24] .. src[7:0], dst[31:24] .. dst[7:0].
- At hdr_cnt = 19 with load: go to PAY, or go to DRAIN if payload_len = 0.
- Latency: the first header byte is valid after the second rising edge following the edge that sampled tx_start.
- PAY: tx_payload_rdy = load. On an accepted payload byte, output it with valid = 1 and decrement rem (initialised to payload_len).
- Underrun in PAY: if load && !tx_payload_v, clear tx_ipv4_data_v (a bubble). No filler byte is inserted.
- When the byte with rem = 1 is accepted, go to DRAIN.
- tx_payload_rdy is 0 in every state other than PAY.
- DRAIN: when tx_ipv4_data_v && tx_ethernet_rdy, clear valid, pulse tx_ipv4_irq for 1 cycle, clear tx_busy, increment the ID counter (wraps at 16'hFFFF to 0), and go to IDLE.
- A start pulse arriving in the same cycle as the irq is ignored; a new frame may start on the following cycle.
- func_en going low mid-frame does not stall the frame; it only gates new starts.
- The latched fields stay stable for the whole frame even if the inputs change.

Test Plan:
- Nominal frame: ip_addr = C0A8010A, tx_dst_ip = C0A80101, len = 8, tx_ethernet_rdy = 1, payload 01..08. Required output: 45 00 00 1C 00 00 40 00 40 11 B7 75 C0 A8 01 0A C0 A8 01 01 01..08 (28 bytes contiguous), then a single irq pulse. The first valid appears 2 cycles after start.
- ID increment: send the same frame twice. The second frame carries ID 00 01 and checksum B7 74.
- Backpressure: toggle tx_ethernet_rdy pseudo-randomly. The byte sequence must be identical to the nominal frame, and data must be held stable while valid && !rdy.
- Payload underrun: drop tx_payload_v for 3 cycles mid-payload. tx_ipv4_data_v must have 3 bubbles, no duplicate or lost bytes, and a total of 28 valid bytes.
- Edge lengths: len = 0 gives 20 header bytes with total_len 00 14 and the irq after byte 20. Starts with func_en = 0, or while tx_busy, produce no output.
- Reset mid-payload: assert rst at byte 24. All outputs go to 0 next cycle, there is no irq, and the next frame starts cleanly with ID 0000.
